// File: rtl/uart_cmd_parser.sv
// ASCII command parser between UART RX and TX: "Lhh<CR>" writes the LED register,
// "R<CR>" reads it back as two hex digits; replies are streamed over valid/ready.
module uart_cmd_parser #(
  parameter int          LED_WIDTH      = 6,
  parameter int          TIMEOUT_CYCLES = 27000000,
  parameter logic [7:0]  LED_RESET      = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [LED_WIDTH-1:0] led_value,
  output logic                 overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE, CMD_L, HEX_HI, HEX_LO, CMD_R, DISCARD, REPLY
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           hi_q, hi_d;
  logic [3:0]           lo_q, lo_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 overrun_q, overrun_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [3:0][7:0]      buf_q, buf_d;
  logic [2:0]           len_q, len_d;
  logic [1:0]           idx_q, idx_d;

  logic       parsing;
  logic       load_err, load_ok, load_sts;
  logic [7:0] led_ext;
  logic [7:0] new_val;

  function automatic logic is_hex(input logic [7:0] d);
    return (d >= 8'h30 && d <= 8'h39) || (d >= 8'h41 && d <= 8'h46) ||
           (d >= 8'h61 && d <= 8'h66);
  endfunction

  // Letters a-f / A-F have bit 6 set and a low nibble of 1..6.
  function automatic logic [3:0] hex_val(input logic [7:0] d);
    return d[6] ? (d[3:0] + 4'd9) : d[3:0];
  endfunction

  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  assign led_ext = 8'(led_q);
  assign new_val = {hi_q, lo_q};
  assign parsing = (state_q == CMD_L) || (state_q == HEX_HI) || (state_q == HEX_LO) ||
                   (state_q == CMD_R) || (state_q == DISCARD);

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    led_d     = led_q;
    overrun_d = overrun_q;
    tmo_d     = '0;
    buf_d     = buf_q;
    len_d     = len_q;
    idx_d     = idx_q;
    load_err  = 1'b0;
    load_ok   = 1'b0;
    load_sts  = 1'b0;

    // An arriving byte always beats timeout expiry on the same cycle.
    if (parsing && !rx_valid) begin
      if (tmo_q == TMO_LAST) state_d = IDLE;
      else                   tmo_d   = tmo_q + TW'(1);
    end

    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_data == 8'h4C || rx_data == 8'h6C)      state_d = CMD_L;
        else if (rx_data == 8'h52 || rx_data == 8'h72) state_d = CMD_R;
        else if (rx_data != CH_CR && rx_data != CH_LF) state_d = DISCARD;
      end
      CMD_L: if (rx_valid) begin
        if (is_hex(rx_data)) begin
          hi_d    = hex_val(rx_data);
          state_d = HEX_HI;
        end else if (rx_data == CH_CR) load_err = 1'b1;
        else                           state_d  = DISCARD;
      end
      HEX_HI: if (rx_valid) begin
        if (is_hex(rx_data)) begin
          lo_d    = hex_val(rx_data);
          state_d = HEX_LO;
        end else if (rx_data == CH_CR) load_err = 1'b1;
        else                           state_d  = DISCARD;
      end
      HEX_LO: if (rx_valid) begin
        if (rx_data == CH_CR) begin
          led_d   = new_val[LED_WIDTH-1:0];
          load_ok = 1'b1;
        end else state_d = DISCARD;
      end
      CMD_R: if (rx_valid) begin
        if (rx_data == CH_CR) load_sts = 1'b1;
        else                  state_d  = DISCARD;
      end
      DISCARD: if (rx_valid && rx_data == CH_CR) load_err = 1'b1;
      REPLY: begin
        if (rx_valid) overrun_d = 1'b1;
        if (tx_ready) begin
          if ({1'b0, idx_q} == len_q - 3'd1) begin
            state_d = IDLE;
            idx_d   = '0;
          end else idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_err || load_ok || load_sts) begin
      state_d = REPLY;
      idx_d   = '0;
      if (load_sts) begin
        buf_d = {CH_LF, CH_CR, to_hex(led_ext[3:0]), to_hex(led_ext[7:4])};
        len_d = 3'd4;
      end else begin
        buf_d = {8'h00, CH_LF, CH_CR, load_ok ? 8'h4B : 8'h45};
        len_d = 3'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      led_q     <= LED_RESET[LED_WIDTH-1:0];
      overrun_q <= 1'b0;
      tmo_q     <= '0;
      buf_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      led_q     <= led_d;
      overrun_q <= overrun_d;
      tmo_q     <= tmo_d;
      buf_q     <= buf_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
    end
  end

  assign tx_valid  = (state_q == REPLY);
  assign tx_data   = (state_q == REPLY) ? buf_q[idx_q] : 8'h00;
  assign led_value = led_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: table of commands with expected replies,
// plus hand-written sequences for backpressure, timeout, overrun and reset.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [5:0] led_value;
  logic       overrun;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] reply_q[$];

  uart_cmd_parser #(.LED_WIDTH(6), .TIMEOUT_CYCLES(16), .LED_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .led_value(led_value), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:4][7:0] cmd;
    int              n_cmd;
    logic [0:3][7:0] rep;
    int              n_rep;
    logic [7:0]      led;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one byte for exactly one clock; called and returns at a negedge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic collectReply(input int budget);
    reply_q.delete();
    for (int i = 0; i < budget; i++) begin
      if (tx_valid) reply_q.push_back(tx_data);
      else if (reply_q.size() > 0) break;
      @(negedge clk);
    end
  endtask

  task automatic checkReply(input string name, input logic [0:3][7:0] rep, input int n);
    checkOutput({name, "_len"}, reply_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < reply_q.size())
        checkOutput($sformatf("%s_byte%0d", name, i), int'(reply_q[i]), int'(rep[i]));
  endtask

  localparam logic [0:3][7:0] REP_K = {8'h4B, 8'h0D, 8'h0A, 8'h00};
  localparam logic [0:3][7:0] REP_E = {8'h45, 8'h0D, 8'h0A, 8'h00};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{cmd: {8'h4C, 8'h32, 8'h61, 8'h0D, 8'h00}, n_cmd: 4, rep: REP_K, n_rep: 3, led: 8'h2A};
    vecs[1]  = '{cmd: {8'h4C, 8'h46, 8'h46, 8'h0D, 8'h00}, n_cmd: 4, rep: REP_K, n_rep: 3, led: 8'h3F};
    vecs[2]  = '{cmd: {8'h72, 8'h0D, 8'h00, 8'h00, 8'h00}, n_cmd: 2,
                 rep: {8'h33, 8'h46, 8'h0D, 8'h0A}, n_rep: 4, led: 8'h3F};
    vecs[3]  = '{cmd: {8'h4C, 8'h47, 8'h0D, 8'h00, 8'h00}, n_cmd: 3, rep: REP_E, n_rep: 3, led: 8'h3F};
    vecs[4]  = '{cmd: {8'h58, 8'h59, 8'h0D, 8'h00, 8'h00}, n_cmd: 3, rep: REP_E, n_rep: 3, led: 8'h3F};
    vecs[5]  = '{cmd: {8'h6C, 8'h30, 8'h35, 8'h0D, 8'h00}, n_cmd: 4, rep: REP_K, n_rep: 3, led: 8'h05};
    vecs[6]  = '{cmd: {8'h52, 8'h0D, 8'h00, 8'h00, 8'h00}, n_cmd: 2,
                 rep: {8'h30, 8'h35, 8'h0D, 8'h0A}, n_rep: 4, led: 8'h05};
    vecs[7]  = '{cmd: {8'h4C, 8'h0D, 8'h00, 8'h00, 8'h00}, n_cmd: 2, rep: REP_E, n_rep: 3, led: 8'h05};
    vecs[8]  = '{cmd: {8'h4C, 8'h31, 8'h0D, 8'h00, 8'h00}, n_cmd: 3, rep: REP_E, n_rep: 3, led: 8'h05};
    vecs[9]  = '{cmd: {8'h4C, 8'h31, 8'h32, 8'h33, 8'h0D}, n_cmd: 5, rep: REP_E, n_rep: 3, led: 8'h05};
    vecs[10] = '{cmd: {8'h0D, 8'h00, 8'h00, 8'h00, 8'h00}, n_cmd: 1, rep: REP_E, n_rep: 0, led: 8'h05};
    vecs[11] = '{cmd: {8'h52, 8'h78, 8'h0D, 8'h00, 8'h00}, n_cmd: 3, rep: REP_E, n_rep: 3, led: 8'h05};

    idleCycles(3);
    checkOutput("reset_tx_valid", int'(tx_valid), 0);
    checkOutput("reset_tx_data", int'(tx_data), 0);
    checkOutput("reset_led", int'(led_value), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    idleCycles(2);

    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < vecs[v].n_cmd; i++) applyStimulus(vecs[v].cmd[i]);
      checkOutput($sformatf("vec%0d_led", v), int'(led_value), int'(vecs[v].led));
      collectReply(12);
      checkReply($sformatf("vec%0d_reply", v), vecs[v].rep, vecs[v].n_rep);
      checkOutput($sformatf("vec%0d_overrun", v), int'(overrun), 0);
      idleCycles(2);
    end

    // Backpressure: reply held for 10 cycles, then drained exactly once.
    begin
      int unstable = 0;
      tx_ready = 1'b0;
      applyStimulus(8'h52);
      applyStimulus(8'h0D);
      checkOutput("stall_first_valid", int'(tx_valid), 1);
      checkOutput("stall_first_data", int'(tx_data), 8'h30);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (tx_valid !== 1'b1 || tx_data !== 8'h30) unstable++;
      end
      checkOutput("stall_stable", unstable, 0);
      tx_ready = 1'b1;
      collectReply(12);
      checkReply("stall_reply", {8'h30, 8'h35, 8'h0D, 8'h0A}, 4);
      idleCycles(2);
    end

    // Partial write abandoned by timeout, then a status read.
    applyStimulus(8'h4C);
    applyStimulus(8'h31);
    collectReply(20);
    checkOutput("timeout_no_reply", reply_q.size(), 0);
    applyStimulus(8'h52);
    applyStimulus(8'h0D);
    collectReply(12);
    checkReply("timeout_status", {8'h30, 8'h35, 8'h0D, 8'h0A}, 4);
    checkOutput("timeout_led", int'(led_value), 8'h05);
    idleCycles(2);

    // Byte landing on the expiry cycle keeps the command alive.
    applyStimulus(8'h4C);
    applyStimulus(8'h31);
    idleCycles(15);
    applyStimulus(8'h32);
    applyStimulus(8'h0D);
    checkOutput("expiry_edge_led", int'(led_value), 8'h12);
    collectReply(12);
    checkReply("expiry_edge_reply", REP_K, 3);
    idleCycles(2);

    // One cycle later the command has already expired.
    applyStimulus(8'h4C);
    applyStimulus(8'h33);
    idleCycles(16);
    applyStimulus(8'h34);
    applyStimulus(8'h0D);
    checkOutput("expired_led", int'(led_value), 8'h12);
    collectReply(12);
    checkReply("expired_reply", REP_E, 3);
    idleCycles(2);

    // Byte during a reply sets overrun and is dropped.
    checkOutput("overrun_before", int'(overrun), 0);
    tx_ready = 1'b0;
    applyStimulus(8'h52);
    applyStimulus(8'h0D);
    applyStimulus(8'h52);
    checkOutput("overrun_set", int'(overrun), 1);
    tx_ready = 1'b1;
    collectReply(12);
    checkReply("overrun_reply", {8'h31, 8'h32, 8'h0D, 8'h0A}, 4);
    collectReply(8);
    checkOutput("overrun_no_extra", reply_q.size(), 0);
    applyStimulus(8'h52);
    applyStimulus(8'h0D);
    collectReply(12);
    checkReply("after_overrun_reply", {8'h31, 8'h32, 8'h0D, 8'h0A}, 4);
    checkOutput("overrun_sticky", int'(overrun), 1);
    idleCycles(2);

    // Reset in the middle of a reply.
    tx_ready = 1'b0;
    applyStimulus(8'h52);
    applyStimulus(8'h0D);
    checkOutput("midreset_pre_valid", int'(tx_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_tx_valid", int'(tx_valid), 0);
    checkOutput("midreset_led", int'(led_value), 0);
    checkOutput("midreset_overrun", int'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    collectReply(8);
    checkOutput("midreset_no_resume", reply_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Downstream consumer of the UART receiver: takes received bytes (byte strobe plus data) and parses a small ASCII command set that sets or reads a 6-bit LED register. Builds short ASCII replies and hands them byte-by-byte over a valid/ready handshake to the UART transmitter. Sits between the RX deserializer and the TX serializer in the board top level; the top level inverts led_value onto the active-low LED pins.

Parameters:
LED_WIDTH, 6, width of led_value; must be 1..8.
TIMEOUT_CYCLES, 27000000, idle clocks allowed between bytes of a partial command (1 s at 27 MHz).
LED_RESET, 0, reset value of led_value.

Ports:
clk  input  1  system clock, 27 MHz.
rst_n  input  1  asynchronous active-low reset.
rx_data  input  8  received byte; valid only when rx_valid=1.
rx_valid  input  1  one-cycle strobe, one per received byte.
tx_data  output  8  reply byte to the UART transmitter.
tx_valid  output  1  tx_data holds a byte to send.
tx_ready  input  1  transmitter accepts tx_data this cycle.
led_value  output  LED_WIDTH  current LED register, active-high.
overrun  output  1  sticky; set when a byte arrives while a reply is being sent.

Behaviour:
- Reset (async assert, sync release): state=IDLE, tx_valid=0, tx_data=0, led_value=LED_RESET, overrun=0, timeout counter=0, reply buffer empty.
- Commands (case-insensitive letters; CR = 0x0D terminates):
  - "L h h CR": h = hex digits 0-9/A-F/a-f; value = {h1,h0}; led_value <= value[LED_WIDTH-1:0]; reply "K" CR LF.
  - "R CR": reply two uppercase hex digits of zero-extended led_value, then CR LF (4 bytes).
  - Any other sequence: error; reply "E" CR LF once the terminating CR arrives.
- States: IDLE, CMD_L, HEX_HI, HEX_LO, CMD_R, DISCARD, REPLY.
  - IDLE: 'L'/'l' -> CMD_L; 'R'/'r' -> CMD_R; LF (0x0A) or CR -> stay, no reply; any other -> DISCARD.
  - CMD_L: hex digit -> HEX_HI (latch high nibble); CR -> REPLY with "E"; else -> DISCARD.
  - HEX_HI: hex digit -> HEX_LO (latch low nibble); CR -> REPLY "E"; else -> DISCARD.
  - HEX_LO: CR -> update led_value, REPLY "K"; else -> DISCARD.
  - CMD_R: CR -> REPLY status; else -> DISCARD.
  - DISCARD: ignore bytes until CR -> REPLY "E".
  - REPLY: present buffered bytes in order; when the last byte is accepted -> IDLE.
- Only bytes with rx_valid=1 are examined; rx_data is ignored otherwise.
- led_value updates on the same clock edge that consumes the CR in HEX_LO; the edge that enters REPLY is that same edge.
- Reply handshake:
  - tx_valid rises on the first cycle in REPLY.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - A byte transfers on each cycle where tx_valid and tx_ready are both high; the next byte is presented the following cycle (tx_valid stays high).
  - tx_valid=0 outside REPLY.
  - The reply buffer holds at most 4 bytes and is loaded in full on entry to REPLY.
- Overrun: rx_valid=1 while in REPLY -> byte dropped, overrun <= 1 (sticky until reset). The command state is unaffected.
- Timeout:
  - In CMD_L, HEX_HI, HEX_LO, CMD_R or DISCARD, the counter increments each cycle without rx_valid.
  - When the counter reaches TIMEOUT_CYCLES-1 -> IDLE silently, no reply. The counter clears on every accepted byte and on entering IDLE.
  - rx_valid on the expiry cycle: the byte wins and is processed normally; the counter clears.
  - The counter is held at 0 in IDLE and REPLY.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1 bits.
- Reset asserted mid-reply: tx_valid drops immediately (asynchronous); the partial reply is discarded and nothing resumes after release.

Test Plan:
- Reset, then bytes "L","2","a",CR with tx_ready=1 -> led_value=0x2A the cycle after CR; tx sequence 0x4B,0x0D,0x0A; overrun=0.
- Same write with "F","F", then "r",CR -> led_value=0x3F; reply "3","F",CR,LF (0x33,0x46,0x0D,0x0A).
- "L","G",CR and "X","Y",CR -> each replies 0x45,0x0D,0x0A; led_value unchanged.
- tx_ready held 0 for 10 cycles during a reply -> tx_data and tx_valid stable throughout; each byte is sent exactly once after tx_ready rises.
- TIMEOUT_CYCLES=16: "L","1", then 20 idle cycles, then "R",CR -> no reply from the partial write; status reply reflects the unchanged led_value. Repeat with a byte arriving exactly on the expiry cycle -> parsing continues.
- Send "R" during an active reply -> overrun=1; no extra reply. Assert rst_n=0 mid-reply -> tx_valid=0 immediately, led_value=LED_RESET.
